// File: rtl/dpwm_pkg.sv
// Shared definitions for the DPWM timing-chain clock divider.
package dpwm_pkg;

  // Counter width; half-period terminal counts up to 2^18-1.
  localparam int CNT_W       = 18;
  // Half-period terminal count after reset (100 MHz -> ~250 Hz).
  localparam int DIV_DEFAULT = 200000;
  // Smallest accepted terminal count; 0 is clamped up to this value.
  localparam int MIN_DIV     = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

endpackage : dpwm_pkg

// File: rtl/div_counter.sv
// Half-period counter: counts 0..term and reports the wrap cycle.
module div_counter #(
  parameter int CNT_W = dpwm_pkg::CNT_W
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  // The >= compare also recovers cleanly if term shrinks below count.
  assign wrap = cnt_en & (count >= term);

  // Count register with synchronous clear taking priority over counting.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    // NOTE: non-blocking assignments on clocked state, so every register sees pre-edge values.
    if (!RST_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule : div_counter

// File: rtl/clk_div_ctrl.sv
// Run-time reconfigurable 50 %-duty clock divider with glitch-free
// ratio changes and low-parking start/stop sequencing.
module clk_div_ctrl #(
  parameter int CNT_W       = dpwm_pkg::CNT_W,
  parameter int DIV_DEFAULT = dpwm_pkg::DIV_DEFAULT
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CFG_VALID,
  input  logic [CNT_W-1:0] CFG_DIV,
  output logic             CFG_READY,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             RUNNING
);

  import dpwm_pkg::*;

  state_e           state;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow;
  logic             pend;

  logic [CNT_W-1:0] count;
  logic             wrap;
  logic             xfer;
  logic             to_idle;
  logic [CNT_W-1:0] cfg_div_c;

  assign CFG_READY = ~pend;
  assign xfer      = CFG_VALID & CFG_READY;
  assign RUNNING   = (state != IDLE);

  // Leaving RUN/STOP: immediately when already low, else on the falling wrap.
  // In STOP, CLK_OUT is always high, so only the falling wrap qualifies.
  assign to_idle = (state != IDLE) & ~EN & (~CLK_OUT | wrap);

  // Clamp a zero divide request to the minimum half-period.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves cfg_div_c unassigned (no latch).
    cfg_div_c = CFG_DIV;
    if (CFG_DIV == '0) cfg_div_c = CNT_W'(MIN_DIV);
  end

  div_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .clr    ((state == IDLE) | to_idle),
    .cnt_en (state != IDLE),
    .term   (active_div),
    .count  (count),
    .wrap   (wrap)
  );

  // Sequencing FSM plus the config handshake and the CLK_OUT/TICK registers.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      active_div <= CNT_W'(DIV_DEFAULT);
      shadow     <= '0;
      pend       <= 1'b0;
      CLK_OUT    <= 1'b0;
      TICK       <= 1'b0;
    end else begin
      TICK <= 1'b0;
      case (state)
        IDLE: begin
          // Divider is stopped, so a new ratio can take effect directly.
          CLK_OUT <= 1'b0;
          if (xfer) active_div <= cfg_div_c;
          if (EN)   state      <= RUN;
        end

        RUN, STOP: begin
          if (to_idle) begin
            state <= IDLE;
            if (wrap && CLK_OUT) begin
              CLK_OUT <= 1'b0;
              TICK    <= 1'b1;
            end
            if (xfer)      active_div <= cfg_div_c;
            else if (pend) active_div <= shadow;
            pend <= 1'b0;
          end else begin
            // Only high-phase runs remain here when EN is low, hence STOP.
            state <= EN ? RUN : STOP;
            if (wrap) begin
              CLK_OUT <= ~CLK_OUT;
              TICK    <= 1'b1;
              if (pend) begin
                active_div <= shadow;
                pend       <= 1'b0;
              end
            end
            // A capture on a wrap cycle waits for the following wrap.
            if (xfer) begin
              shadow <= cfg_div_c;
              pend   <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : clk_div_ctrl

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable, run-time reconfigurable clock divider controller for the DPWM timing chain.
- Generates the 50 %-duty divided clock and a one-cycle TICK enable from the 100 MHz system clock.
- Divide ratio is loaded through a valid/ready handshake and applied only at a half-period boundary, so CLK_OUT never glitches.
- Start and stop are sequenced so CLK_OUT always parks low.

Parameters:
CNT_W, 18, counter width; supports half-period values up to 2^18-1.
DIV_DEFAULT, 200000, half-period terminal count after reset (100 MHz -> ~250 Hz).

Ports:
CLK_IN  input  1  system clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  level; 1 = run divider, 0 = stop at next low phase
CFG_VALID  input  1  new divide value offered
CFG_DIV  input  CNT_W  new half-period terminal count
CFG_READY  output  1  controller can accept CFG_DIV
CLK_OUT  output  1  divided clock, registered
TICK  output  1  one-cycle strobe, coincident with every CLK_OUT toggle
RUNNING  output  1  1 in RUN or STOP state

Behaviour:
- Reset (RST_N=0, asynchronous): count=0, CLK_OUT=0, TICK=0, active_div=DIV_DEFAULT, shadow=0, pend=0, CFG_READY=1, state IDLE.
- Half-period = active_div+1 cycles. Full period = 2*(active_div+1) cycles.
- Wrap event = (count >= active_div) in RUN/STOP. On wrap: count<=0, CLK_OUT<=~CLK_OUT, TICK<=1 for one cycle. Otherwise count<=count+1 and TICK<=0.
- CFG_DIV value 0 is clamped to 1 on capture, giving a minimum half-period of 2 cycles.
- Handshake: transfer occurs when CFG_VALID & CFG_READY. CFG_READY = ~pend.
- States:
  - IDLE
    - count held 0, CLK_OUT 0.
    - A transfer writes active_div directly on the next edge; pend stays 0.
    - EN=1 -> RUN. The first toggle occurs active_div+1 cycles after entry.
    - EN=1 and a transfer in the same cycle: RUN starts with the new value.
  - RUN
    - Counts and wraps.
    - A transfer captures shadow and sets pend=1.
    - At the next wrap with pend=1: active_div<=shadow, pend<=0.
    - A transfer in the same cycle as a wrap is not applied on that wrap; it is applied on the following wrap.
    - EN=0 with CLK_OUT=0 -> IDLE next cycle, count cleared. A pending shadow is applied on entry to IDLE.
    - EN=0 with CLK_OUT=1 -> STOP.
  - STOP
    - Counts as RUN.
    - The wrap that drives CLK_OUT 1->0 (TICK still pulses) moves to IDLE; pending shadow is applied.
    - EN re-asserted while in STOP -> RUN with no phase disturbance.
    - Transfers are accepted as in RUN.
- RUNNING = (state != IDLE).
- Outputs are registered; no combinational path from inputs to CLK_OUT/TICK.
- CFG_READY is combinational from pend only.
- Reset asserted mid-operation: all outputs return immediately to their reset values, and any pending config is discarded.

Decomposition:
- Shared package dpwm_pkg holds:
  - state enum {IDLE, RUN, STOP};
  - CNT_W;
  - DIV_DEFAULT;
  - MIN_DIV=1.
- Natural sub-module: div_counter. It holds the count register, the >= compare, wrap output, synchronous clear and count-enable inputs.
- clk_div_ctrl owns the FSM, the shadow/pend handshake, and the CLK_OUT/TICK registers.

Test Plan:
- Reset, then EN=1 with DIV_DEFAULT overridden to 3 -> CLK_OUT period 8 cycles, TICK every 4 cycles, first TICK 4 cycles after RUN entry, CLK_OUT=0 during reset.
- In RUN with div=3, offer CFG_DIV=5 mid half-period -> CFG_READY drops next cycle. The current half-period stays 4 cycles; subsequent half-periods are 6 cycles; CFG_READY returns to 1 at that wrap.
- Offer CFG_DIV=9 in the exact cycle of a wrap with div=3 -> the next half-period is still 4 cycles, then 10. Offer CFG_DIV=0 -> half-period 2 cycles.
- Deassert EN while CLK_OUT=1 -> CLK_OUT finishes its high half, falls with TICK, RUNNING=0, count=0. Deassert EN while CLK_OUT=0 -> IDLE next cycle with no extra TICK.
- Stop/restart: deassert EN during the high half, then re-assert it before the wrap -> no phase change and the period is unchanged.
- Stop with a pending config: deassert EN with a pending CFG_DIV=7, then restart -> the new value is used from the first half-period.
- Assert RST_N=0 asynchronously mid-count with a pending config -> CLK_OUT, TICK, RUNNING go 0 and CFG_READY goes 1 without a clock edge. After release, the half-period is DIV_DEFAULT+1 and the pending value is gone.
